// File: rtl/aes_mode_ctrl_if.sv
// Stream-in, stream-out and cipher-core handshake bundle for aes_mode_ctrl.
// The slave modport is the controller side; master is the environment side.
interface aes_mode_ctrl_if #(
    parameter int BLOCK_W = 128,
    parameter int KEY_W   = 128
);
    logic               in_valid;
    logic               in_ready;
    logic [BLOCK_W-1:0] in_data;
    logic               in_last;
    logic               out_valid;
    logic               out_ready;
    logic [BLOCK_W-1:0] out_data;
    logic               out_last;
    logic               core_start;
    logic               core_decrypt;
    logic [KEY_W-1:0]   core_key;
    logic [BLOCK_W-1:0] core_din;
    logic [BLOCK_W-1:0] core_dout;
    logic               core_done;

    modport slave (
        input  in_valid, in_data, in_last, out_ready, core_dout, core_done,
        output in_ready, out_valid, out_data, out_last,
               core_start, core_decrypt, core_key, core_din
    );

    modport master (
        output in_valid, in_data, in_last, out_ready, core_dout, core_done,
        input  in_ready, out_valid, out_data, out_last,
               core_start, core_decrypt, core_key, core_din
    );
endinterface

// File: rtl/aes_mode_ctrl.sv
// ECB/CBC/CTR chaining controller around a single-block AES core.
// One block is in flight at a time; all chaining state lives here.
module aes_mode_ctrl #(
    parameter int BLOCK_W = 128,
    parameter int KEY_W   = 128,
    parameter int CTR_W   = 32,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         mode,
    input  logic               decrypt,
    input  logic [KEY_W-1:0]   key,
    input  logic [BLOCK_W-1:0] iv,
    aes_mode_ctrl_if.slave     bus,
    output logic               busy,
    output logic               mode_err,
    output logic [CNT_W-1:0]   blk_count
);
    typedef enum logic [2:0] {IDLE, WAIT_IN, CORE_GO, CORE_WAIT, OUT} state_e;
    typedef enum logic [1:0] {ECB = 2'b00, CBC = 2'b01, CTR = 2'b10, RSV = 2'b11} mode_e;

    state_e             state, state_nxt;
    mode_e              mode_q;
    logic               dec_q;
    logic [KEY_W-1:0]   key_q;
    logic [BLOCK_W-1:0] chain_q;
    logic [BLOCK_W-1:0] blk_q;
    logic               last_q;
    logic [BLOCK_W-1:0] out_q;
    logic               out_last_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               err_q;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        bus.in_ready   = 1'b0;
        bus.out_valid  = 1'b0;
        bus.core_start = 1'b0;
        busy           = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start && (mode != 2'b11)) state_nxt = WAIT_IN;
            end
            WAIT_IN: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) state_nxt = CORE_GO;
            end
            CORE_GO: begin
                bus.core_start = 1'b1;
                state_nxt      = CORE_WAIT;
            end
            CORE_WAIT: begin
                if (bus.core_done) state_nxt = OUT;
            end
            OUT: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_nxt = out_last_q ? IDLE : WAIT_IN;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // core_din is built from registers only, so it stays stable for the whole core operation.
    always_comb begin
        bus.core_din = blk_q;
        if (mode_q == CTR)                 bus.core_din = chain_q;
        else if (mode_q == CBC && !dec_q)  bus.core_din = blk_q ^ chain_q;
    end

    assign bus.core_decrypt = dec_q && (mode_q != CTR);
    assign bus.core_key     = key_q;
    assign bus.out_data     = out_q;
    assign bus.out_last     = out_last_q;
    assign mode_err         = err_q;
    assign blk_count        = cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q     <= ECB;
            dec_q      <= 1'b0;
            key_q      <= '0;
            chain_q    <= '0;
            blk_q      <= '0;
            last_q     <= 1'b0;
            out_q      <= '0;
            out_last_q <= 1'b0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (mode == 2'b11) begin
                            err_q <= 1'b1;
                        end else begin
                            mode_q  <= mode_e'(mode);
                            dec_q   <= decrypt;
                            key_q   <= key;
                            chain_q <= iv;
                            cnt_q   <= '0;
                            err_q   <= 1'b0;
                        end
                    end
                end
                WAIT_IN: begin
                    if (bus.in_valid) begin
                        blk_q  <= bus.in_data;
                        last_q <= bus.in_last;
                    end
                end
                CORE_WAIT: begin
                    if (bus.core_done) begin
                        out_last_q <= last_q;
                        case (mode_q)
                            CBC: begin
                                if (dec_q) begin
                                    out_q   <= bus.core_dout ^ chain_q;
                                    chain_q <= blk_q;
                                end else begin
                                    out_q   <= bus.core_dout;
                                    chain_q <= bus.core_dout;
                                end
                            end
                            CTR: begin
                                out_q                <= bus.core_dout ^ blk_q;
                                chain_q[CTR_W-1:0]   <= chain_q[CTR_W-1:0] + CTR_W'(1);
                            end
                            default: out_q <= bus.core_dout;
                        endcase
                    end
                end
                OUT: begin
                    if (bus.out_ready) cnt_q <= cnt_q + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/aes_mode_ctrl.md
Name: aes_mode_ctrl

Overview:
Parametrised block-cipher mode controller that sits between a streaming data interface and the team's AES-128 encryption/decryption cores. It adds ECB, CBC and CTR chaining over multi-block messages, which the single-block cores do not provide. It also adds run-time direction select and valid/ready flow control on both input and output. The controller sequences the core through an external start/done interface and owns all chaining state: IV register, counter and block count.

Parameters:
BLOCK_W, 128, cipher block width in bits; must equal the core width.
KEY_W, 128, key width passed through to the core.
CTR_W, 32, width of the incrementing low field of the CTR counter block (1..BLOCK_W).
CNT_W, 16, width of the processed-block counter.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  synchronous, active-high reset.
start  in  1  message start pulse; sampled only in IDLE.
mode  in  2  00 ECB, 01 CBC, 10 CTR, 11 reserved; latched on start.
decrypt  in  1  1 = decrypt, 0 = encrypt; latched on start.
key  in  KEY_W  key; latched on start.
iv  in  BLOCK_W  CBC IV or CTR initial counter block; latched on start.
in_valid  in  1  input block valid.
in_ready  out  1  controller can accept an input block.
in_data  in  BLOCK_W  input block (plaintext or ciphertext).
in_last  in  1  marks the final block of the message.
out_valid  out  1  output block valid.
out_ready  in  1  downstream accepts the output block.
out_data  out  BLOCK_W  output block.
out_last  out  1  copy of in_last for this block.
core_start  out  1  one-cycle start pulse to the core.
core_decrypt  out  1  selects the decryption core (1) or encryption core (0).
core_key  out  KEY_W  latched key.
core_din  out  BLOCK_W  core input block, held stable from core_start until core_done.
core_dout  in  BLOCK_W  core result; valid while core_done is high.
core_done  in  1  core completion flag.
busy  out  1  high in every state except IDLE.
mode_err  out  1  sticky; set when start arrives with mode = 11.
blk_count  out  CNT_W  blocks emitted since the last start; wraps modulo 2^CNT_W.

Behaviour:
- Reset (synchronous, any state): FSM goes to IDLE. in_ready, out_valid, out_last, core_start, busy, mode_err and blk_count all clear to 0. Data registers, core_din and out_data clear to 0.
- FSM states: IDLE, WAIT_IN, CORE_GO, CORE_WAIT, OUT.
- IDLE, start=1, mode≠11: latch mode, decrypt, key and iv into chain_reg; clear blk_count and mode_err; go to WAIT_IN.
- IDLE, start=1, mode=11: set mode_err and stay in IDLE.
- IDLE, start=0: stay. start is ignored in every other state.
- WAIT_IN: in_ready=1. On in_valid&in_ready, latch in_data and in_last, then go to CORE_GO.
- CORE_GO: core_start=1 for exactly one cycle, with core_din driven as below; go to CORE_WAIT.
- CORE_WAIT: on the first cycle with core_done=1, capture core_dout, form out_data, update chain_reg, then go to OUT.
- OUT: out_valid=1, with out_data/out_last held stable until out_ready. On the handshake cycle blk_count increments. The next state is IDLE if out_last=1, else WAIT_IN.
- Mode datapath (P = latched input, C = chain_reg, E = core_dout):
  - ECB: core_decrypt = decrypt; core_din = P; out = E.
  - CBC encrypt: core_decrypt = 0; core_din = P^C; out = E; C <= E.
  - CBC decrypt: core_decrypt = 1; core_din = P; out = E^C; C <= P.
  - CTR: core_decrypt = 0 regardless of decrypt; core_din = C; out = E^P. C[CTR_W-1:0] increments modulo 2^CTR_W; upper bits are unchanged, with no carry into them.
- Latency per block: 1 cycle accept, 1 cycle start, core latency, 1 cycle capture; output is available the cycle after core_done.
- Only one block is in flight at a time: in_ready=0 from acceptance until the output handshake completes.
- core_done already high in CORE_GO is ignored; only core_done seen in CORE_WAIT counts.
- Reset mid-message: in-flight output is discarded, no out_valid appears, and chain state is lost.

Test Plan:
1. ECB encrypt, key 000102030405060708090a0b0c0d0e0f, in 00112233445566778899aabbccddeeff, in_last=1 -> out 69c4e0d86a7b0430d8cdb78070b4c55a, out_last=1, blk_count=1, FSM returns to IDLE. ECB decrypt of that output -> original plaintext.
2. CBC encrypt, key 2b7e151628aed2a6abf7158809cf4f3c, iv 000102…0f, P1 6bc1bee22e409f96e93d7e117393172a, P2 ae2d8a571e03ac9c9eb76fac45af8e51 -> 7649abac8119b246cee98e9b12e9197d then 5086cb9b507219ee95db113a917678b2. CBC decrypt of those two blocks -> P1, P2.
3. CTR, same key, iv f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff, P1, P2 -> 874d6191b620e3261bef6864990db6ce then 9806f66b7970fdff8617187bb9fffdff. The second core_din must be …fcfdff00.
4. CTR wrap: iv low 32 bits ffffffff, 2 blocks -> second core_din has low 32 bits 00000000 and upper 96 bits unchanged.
5. Backpressure: hold out_ready=0 for 5 cycles -> out_valid and out_data stable, in_ready=0, blk_count unchanged; it increments on the cycle out_ready rises.
6. start with mode=11 -> mode_err=1, busy=0. Separately, assert reset during CORE_WAIT -> next cycle IDLE, all outputs 0, no out_valid.
